// File: rtl/scope_pkg.sv
// Shared constants for the scope capture path: FSM state codes and trigger modes.
package scope_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_POST    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] M_NORMAL  = 2'd0;
    localparam logic [1:0] M_AUTO    = 2'd1;
    localparam logic [1:0] M_SINGLE  = 2'd2;

endpackage

// File: rtl/sample_dpram.sv
// Simple dual-port sample store: one write port, one registered read port.
module sample_dpram #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [SAMPLE_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [SAMPLE_WIDTH-1:0] rdata
);

    logic [SAMPLE_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write port: contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one-cycle registered read; output reads as zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else       rdata <= mem[raddr];
    end

endmodule

// File: rtl/trigger_capture.sv
// Edge trigger with hysteresis, pre-trigger history in a circular buffer,
// auto/single-shot modes and a dual-port sample store for the renderer.
module trigger_capture
    import scope_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int N_SAMPLES    = 600,
    parameter int AUTO_TIMEOUT = 1000000,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] trig_level,
    input  logic [SAMPLE_WIDTH-1:0] hyst,
    input  logic                    edge_sel,
    input  logic [1:0]              mode,
    input  logic [ADDR_WIDTH-1:0]   pretrig,
    input  logic                    arm_en,
    input  logic                    frame_start,
    input  logic                    rearm,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    busy,
    output logic                    captured,
    output logic                    auto_fired,
    output logic [COUNT_WIDTH-1:0]  trig_count,
    output logic [2:0]              state
);

    localparam int                  TMO_W   = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] P_MAX_W = (ADDR_WIDTH+1)'(N_SAMPLES - 1);
    localparam logic [ADDR_WIDTH-1:0] P_MAX = ADDR_WIDTH'(N_SAMPLES - 1);

    function automatic logic [SAMPLE_WIDTH-1:0] sat_sub(input logic [SAMPLE_WIDTH-1:0] a,
                                                        input logic [SAMPLE_WIDTH-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] sat_add(input logic [SAMPLE_WIDTH-1:0] a,
                                                        input logic [SAMPLE_WIDTH-1:0] b);
        logic [SAMPLE_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SAMPLE_WIDTH] ? '1 : s[SAMPLE_WIDTH-1:0];
    endfunction

    // Configuration frozen at IDLE exit
    logic [SAMPLE_WIDTH-1:0] level_q, hyst_q;
    logic                    edge_q;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   pretrig_q;

    logic [ADDR_WIDTH-1:0]   wr_ptr, start_ptr, pre_cnt, post_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [2:0]              state_n;

    logic [SAMPLE_WIDTH-1:0] arm_thr;
    logic [ADDR_WIDTH-1:0]   pretrig_clamped, post_init;
    logic                    arm_hit, fire_hit, tmo_hit, writing, genuine, forced, fire;
    logic                    watching;

    assign pretrig_clamped = ({1'b0, pretrig} > P_MAX_W) ? P_MAX : pretrig;
    assign post_init       = P_MAX - pretrig_q;
    assign arm_thr         = edge_q ? sat_add(level_q, hyst_q) : sat_sub(level_q, hyst_q);
    assign arm_hit         = edge_q ? (sample > arm_thr) : (sample < arm_thr);
    assign fire_hit        = edge_q ? (sample <= level_q) : (sample >= level_q);
    assign watching        = (state == S_ARMED) || (state == S_READY);
    assign tmo_hit         = (mode_q == M_AUTO) && (tmo_cnt == TMO_W'(AUTO_TIMEOUT));
    assign writing         = sample_valid && (state >= S_PREFILL) && (state <= S_POST);
    // Arming and firing are evaluated in different states, so one sample can never do both.
    assign genuine         = (state == S_READY) && sample_valid && fire_hit;
    assign forced          = watching && sample_valid && tmo_hit && !genuine;
    assign fire            = genuine || forced;

    assign busy            = (state != S_IDLE) && (state != S_DONE);
    assign captured        = (state == S_DONE);

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (arm_en) state_n = S_PREFILL;
            S_PREFILL: if (pre_cnt == pretrig_q) state_n = S_ARMED;
            S_ARMED: begin
                if (fire)                         state_n = (post_init == '0) ? S_DONE : S_POST;
                else if (sample_valid && arm_hit) state_n = S_READY;
            end
            S_READY:   if (fire) state_n = (post_init == '0) ? S_DONE : S_POST;
            S_POST:    if (sample_valid && post_cnt == ADDR_WIDTH'(1)) state_n = S_DONE;
            S_DONE: begin
                if (mode_q == M_SINGLE) begin
                    if (rearm) state_n = S_IDLE;
                end else if (frame_start) begin
                    state_n = S_IDLE;
                end
            end
            default:   state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Latch trigger configuration when leaving IDLE; later input changes are ignored
    always_ff @(posedge clk) begin
        if (state == S_IDLE && arm_en) begin
            level_q   <= trig_level;
            hyst_q    <= hyst;
            edge_q    <= edge_sel;
            mode_q    <= mode;
            pretrig_q <= pretrig_clamped;
        end
    end

    // Circular write pointer and the window start fixed at the trigger sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
        end else begin
            if (writing) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (fire)    start_ptr <= wr_ptr - pretrig_q;
        end
    end

    // Pre-trigger fill count and post-trigger countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt  <= '0;
            post_cnt <= '0;
        end else begin
            if (state == S_IDLE)                         pre_cnt <= '0;
            else if (state == S_PREFILL && sample_valid) pre_cnt <= pre_cnt + ADDR_WIDTH'(1);
            if (fire)                                    post_cnt <= post_init;
            else if (state == S_POST && sample_valid)    post_cnt <= post_cnt - ADDR_WIDTH'(1);
        end
    end

    // Auto-mode timeout: counts clocks while waiting, restarts on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                 tmo_cnt <= '0;
        else if (state_n != state || mode_q != M_AUTO || !watching) tmo_cnt <= '0;
        else if (!tmo_hit)                                         tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Trigger statistics: count every fire, remember whether the last one was forced
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_count <= '0;
            auto_fired <= 1'b0;
        end else begin
            if (fire)    trig_count <= trig_count + COUNT_WIDTH'(1);
            if (genuine) auto_fired <= 1'b0;
            else if (forced) auto_fired <= 1'b1;
        end
    end

    sample_dpram #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (writing),
        .waddr (wr_ptr),
        .wdata (sample),
        .raddr (start_ptr + rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
Parametrised trigger and sample-capture engine for the scope datapath. It is the successor to the inline trigger FSM in the top level. It adds:
- rising/falling edge select
- hysteresis
- pre-trigger history via a circular buffer
- auto and single-shot modes
- a dual-port sample store, so the display reads without an address mux.

It sits between the ADC (sample/valid) and the waveform renderer (rd_addr/rd_data), all in the vga_clk domain.

Parameters:
SAMPLE_WIDTH, 16, bits per stored sample
ADDR_WIDTH, 10, buffer address width; DEPTH = 2**ADDR_WIDTH
N_SAMPLES, 600, samples per capture window (2..DEPTH)
AUTO_TIMEOUT, 1000000, clocks without trigger before auto mode forces one
COUNT_WIDTH, 16, width of trig_count

Ports:
clk  in  1  system clock (vga_clk)
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe, new ADC sample
sample  in  SAMPLE_WIDTH  ADC sample, unsigned
trig_level  in  SAMPLE_WIDTH  trigger threshold
hyst  in  SAMPLE_WIDTH  arming hysteresis
edge_sel  in  1  0 = rising, 1 = falling
mode  in  2  0 = normal, 1 = auto, 2 = single, 3 = reserved (treated as normal)
pretrig  in  ADDR_WIDTH  samples kept before trigger
arm_en  in  1  capture window (display blanking)
frame_start  in  1  one-cycle strobe at top of frame
rearm  in  1  one-cycle strobe, releases single-shot DONE
rd_addr  in  ADDR_WIDTH  display index 0..N_SAMPLES-1
rd_data  out  SAMPLE_WIDTH  sample at rd_addr, 1-cycle latency
busy  out  1  high when not in IDLE or DONE
captured  out  1  high in DONE (buffer frozen, valid)
auto_fired  out  1  last capture was forced by timeout
trig_count  out  COUNT_WIDTH  triggers since reset, wraps
state  out  3  FSM state, for debug pin

Behaviour:
Reset:
- state = IDLE; wr_ptr = 0; start_ptr = 0.
- busy, captured, auto_fired = 0; trig_count = 0; timeout counter = 0.
- rd_data = 0 until first read after reset.
- Buffer contents are undefined.

Configuration latch (on IDLE exit):
- Latch level, hyst, edge, mode.
- pretrig is clamped to N_SAMPLES-1.
- Input changes mid-capture have no effect.

Thresholds (unsigned, saturating):
- Rising: arm_thr = level - hyst (floor 0); armed when sample < arm_thr; fire when sample >= level.
- Falling: arm_thr = level + hyst (ceiling 2**SAMPLE_WIDTH - 1); armed when sample > arm_thr; fire when sample <= level.

Write rule:
- In PREFILL, ARMED and READY, every sample_valid writes sample at wr_ptr, then wr_ptr+1 (mod DEPTH).
- In POST, writes occur the same way.
- No writes in IDLE or DONE.

FSM:
- IDLE: when arm_en=1, latch config, clear prefill count → PREFILL.
- PREFILL: count written samples; when count == pretrig → ARMED (pretrig = 0 → ARMED next cycle).
- ARMED: on a valid sample meeting the arm condition → READY.
- READY: on a valid sample meeting the fire condition:
  - trig_ptr = wr_ptr of that sample
  - start_ptr = trig_ptr - pretrig (mod DEPTH)
  - trig_count + 1; post count = N_SAMPLES - pretrig - 1
  - → POST (or straight to DONE if post count is 0).
- POST: decrement post count per written sample; at 0 → DONE.
- DONE: captured = 1, buffer frozen.
  - Normal/auto: on frame_start → IDLE.
  - Single: only rearm → IDLE; frame_start is ignored.

Auto mode:
- Timeout counter runs in ARMED and READY, clears on state entry.
- At AUTO_TIMEOUT, the next valid sample is treated as a fire; auto_fired = 1 and trig_count increments.
- auto_fired clears on the next genuine trigger.
- In normal/single mode the counter is held at 0.

Read port:
- Physical read address = start_ptr + rd_addr (mod DEPTH).
- Synchronous read, registered rd_data.
- Reading is legal in any state; data is meaningful only while captured = 1.
- rd_addr >= N_SAMPLES returns stale buffer data; there is no error flag.

Simultaneous events:
- A fire on the same sample that completes the arm condition is not allowed; arming and firing require separate samples.
- frame_start and rearm in the same cycle in single mode → IDLE.
- arm_en dropping after IDLE exit does not abort the capture.

Reset mid-operation: immediate return to IDLE; partial capture discarded; captured = 0.

Decomposition:
- Shared package scope_pkg: state encodings (S_IDLE=0, S_PREFILL=1, S_ARMED=2, S_READY=3, S_POST=4, S_DONE=5) and mode constants (M_NORMAL, M_AUTO, M_SINGLE).
- One sub-module: sample_dpram, a simple dual-port RAM (one write port, one registered read port) parametrised by SAMPLE_WIDTH and ADDR_WIDTH, inferable to iCE40 BRAM.

Test Plan:
1. Rising, level=300, hyst=20, pretrig=0, N=600; ramp 0→1000 repeated, arm_en=1 → trigger at first sample ≥300 after a sample <280; rd_addr 0 returns 300; captured after 600 valid samples; trig_count=1.
2. Falling edge, pretrig=100; sine input → rd_addr 100 is the first sample ≤ level; rd_addr 99 is > level.
3. Auto mode, AUTO_TIMEOUT=50, constant input 10, level=300 → captured after ~50 clocks plus one sample; auto_fired=1; trig_count=1.
4. Single mode: capture, then 3 frame_start strobes → stays DONE; rearm → IDLE; second capture increments trig_count to 2.
5. Wrap-around: ADDR_WIDTH=4, N_SAMPLES=12, pretrig=5, trigger after 30 samples → rd_addr 0..11 return the correct contiguous samples across the buffer wrap.
6. Assert reset during POST → state=0, captured=0, busy=0 next edge; fresh capture succeeds; hyst large (level=10, hyst=50, rising) → arm_thr saturates at 0, never arms, captured stays 0.
